// File: rtl/veda_pkg.sv
// Shared encodings, widths and types for the veda register-file controller.
package veda_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  localparam logic RF_MODE_WRITE = 1'b0;
  localparam logic RF_MODE_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/veda_cmd_fifo.sv
// Command FIFO for veda_ctrl; DEPTH must be a power of two >= 2.
module veda_cmd_fifo
  import veda_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/veda_ctrl.sv
// Register-file access controller: queues write/read commands and sequences them one at a time.
// Optional macro VEDA_CTRL_UNINIT_CHK_EN adds a written-address mask that flags reads of never-written registers.
module veda_ctrl
  import veda_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rf_write_enable,
  output logic              rf_mode,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  output logic [DATA_W-1:0] rf_datain,
  input  logic [DATA_W-1:0] rf_dataout
);

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  cmd_t       push_cmd;
  cmd_t       head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       sample;
  state_t     state;
  logic [2:0] cnt;

  assign push_cmd  = '{op: cmd_op, addr_a: cmd_addr_a, addr_b: cmd_addr_b, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;
  assign pop       = (state == IDLE) && !fifo_empty;

  // ISSUE doubles as the first read-wait cycle so RD_LAT=1 samples on the edge leaving ISSUE.
  assign sample = ((state == ISSUE) || (state == WAIT)) && (rf_mode == RF_MODE_READ) && (cnt == '0);

  veda_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_valid),
    .pop  (pop),
    .din  (push_cmd),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rf_write_enable <= 1'b0;
      rf_mode         <= RF_MODE_READ;
      rf_addr_a       <= '0;
      rf_addr_b       <= '0;
      rf_datain       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= ISSUE;
            cnt       <= LAT_M1;
            rf_addr_a <= head.addr_a;
            rf_addr_b <= head.addr_b;
            if (head.op == OP_WRITE) begin
              rf_write_enable <= 1'b1;
              rf_mode         <= RF_MODE_WRITE;
              rf_datain       <= head.wdata;
            end else begin
              rf_write_enable <= 1'b0;
              rf_mode         <= RF_MODE_READ;
              rf_datain       <= '0;
            end
          end
        end
        ISSUE, WAIT: begin
          if ((rf_mode == RF_MODE_WRITE) || sample) begin
            rf_write_enable <= 1'b0;
            rf_mode         <= RF_MODE_READ;
            rf_addr_a       <= '0;
            rf_addr_b       <= '0;
            rf_datain       <= '0;
            if (sample) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= rf_dataout;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt   <= cnt - 3'd1;
            state <= WAIT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VEDA_CTRL_UNINIT_CHK_EN
  logic [(2**ADDR_W)-1:0] wr_mask;
  logic                   err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_mask <= '0;
      err_q   <= 1'b0;
    end else begin
      if (pop && (head.op == OP_WRITE)) wr_mask[head.addr_a] <= 1'b1;
      if (sample) err_q <= ~wr_mask[rf_addr_a];
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
